// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB3 request master.
package apb_master_pkg;

  localparam int unsigned APB_DATA_WIDTH         = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;

  // Timeout counter width; a disabled timeout still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase cycle counter; flags the last permitted wait cycle.
module apb_timeout_cnt
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_limit_c
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_limit_c = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/apb_req_master.sv
// APB3 initiator: turns one valid/ready request into a single APB transfer
// and returns the result (data, slave error, timeout) on a valid/ready response.
module apb_req_master
  import apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_write_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_state_e                r_state;
  apb_state_e                w_state_nxt;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_pwrite;
  apb_rsp_t                  r_rsp;
  logic                      w_limit;
  logic                      w_cnt_clr;
  logic                      w_cnt_en;

  assign w_cnt_clr = (r_state == SETUP);
  assign w_cnt_en  = (r_state == ACCESS) && !PREADY;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_limit_c(w_limit)
  );

  // State register; async reset drops the bus controls immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; PREADY takes priority over the timeout abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid_i) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (PREADY || w_limit) w_state_nxt = RESP;
      RESP:    if (rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control outputs decoded from the state register.
  always_comb begin
    req_ready_o = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    rsp_valid_o = 1'b0;
    case (r_state)
      IDLE:   req_ready_o = 1'b1;
      SETUP:  PSEL        = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      RESP:   rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Request capture and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_rsp    <= '0;
    end else begin
      if ((r_state == IDLE) && req_valid_i) begin
        r_paddr  <= req_addr_i;
        r_pwdata <= req_wdata_i;
        r_pwrite <= req_write_i;
      end
      if (r_state == ACCESS) begin
        if (PREADY) begin
          r_rsp.rdata   <= r_pwrite ? '0 : PRDATA;
          r_rsp.err     <= PSLVERR;
          r_rsp.timeout <= 1'b0;
        end else if (w_limit) begin
          r_rsp.rdata   <= '0;
          r_rsp.err     <= 1'b1;
          r_rsp.timeout <= 1'b1;
        end
      end
    end
  end

  assign PADDR         = r_paddr;
  assign PWDATA        = r_pwdata;
  assign PWRITE        = r_pwrite;
  assign rsp_rdata_o   = r_rsp.rdata;
  assign rsp_err_o     = r_rsp.err;
  assign rsp_timeout_o = r_rsp.timeout;

endmodule

// File: tb/tb_apb_req_master.sv
// Scenario-driven bench for apb_req_master with a response scoreboard.
module tb_apb_req_master;
  import apb_master_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_write_i;
  logic [31:0]   req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb_rsp_t sb_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  apb_req_master #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_write_i  (req_write_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PWRITE       (PWRITE),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR)
  );

  // Response monitor: every accepted response is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fails++;
        $display("FAIL sb_unexpected_rsp: got rdata=%h err=%b to=%b with nothing expected",
                 rsp_rdata_o, rsp_err_o, rsp_timeout_o);
      end else begin
        apb_rsp_t exp_r;
        apb_rsp_t got_r;
        exp_r = sb_q.pop_front();
        got_r = '{rdata: rsp_rdata_o, err: rsp_err_o, timeout: rsp_timeout_o};
        if (got_r !== exp_r) begin
          n_fails++;
          $display("FAIL sb_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
                   got_r.rdata, got_r.err, got_r.timeout,
                   exp_r.rdata, exp_r.err, exp_r.timeout);
        end
      end
    end
  end

  // Drives one request and a slave that inserts 'waits' wait states (-1 = never ready).
  task automatic run_xfer(input logic [AW-1:0] addr, input logic write,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic slverr, input int waits,
                          output int lat, output int n_access, output bit bus_ok);
    apb_rsp_t exp_r;
    lat      = 0;
    n_access = 0;
    bus_ok   = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_write_i = write;
    req_wdata_i = wdata;
    if (waits < 0 || waits >= int'(TO)) exp_r = '{rdata: 32'h0, err: 1'b1, timeout: 1'b1};
    else exp_r = '{rdata: (write ? 32'h0 : rdata), err: slverr, timeout: 1'b0};
    @(negedge clk);
    sb_q.push_back(exp_r);
    req_valid_i = 1'b0;
    req_addr_i  = AW'($urandom);
    req_wdata_i = $urandom;
    lat = 1;
    while (!rsp_valid_o && lat < 40) begin
      if (lat == 1 && !(PSEL && !PENABLE)) bus_ok = 1'b0;
      if (lat > 1 && !(PSEL && PENABLE)) bus_ok = 1'b0;
      if (PADDR !== addr || PWRITE !== write || PWDATA !== wdata || req_ready_o) bus_ok = 1'b0;
      PREADY  = 1'b0;
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom);
      if (PSEL && PENABLE) begin
        n_access++;
        if (waits >= 0 && n_access - 1 == waits) begin
          PREADY  = 1'b1;
          PRDATA  = rdata;
          PSLVERR = slverr;
        end
      end
      @(negedge clk);
      lat++;
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
  endtask

  // Holds rsp_ready low for 'hold' cycles, recording whether RESP stays stable, then accepts.
  task automatic finish_rsp(input int hold, output bit hold_ok);
    apb_rsp_t snap;
    snap    = '{rdata: rsp_rdata_o, err: rsp_err_o, timeout: rsp_timeout_o};
    hold_ok = rsp_valid_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!(rsp_valid_o && !req_ready_o && !PSEL && !PENABLE)) hold_ok = 1'b0;
      if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== snap) hold_ok = 1'b0;
    end
    @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    n_checks += 10;
    if (PSEL !== 1'b0)          begin n_fails++; $display("FAIL rst_psel: got %b expected 0", PSEL); end
    if (PENABLE !== 1'b0)       begin n_fails++; $display("FAIL rst_penable: got %b expected 0", PENABLE); end
    if (PWRITE !== 1'b0)        begin n_fails++; $display("FAIL rst_pwrite: got %b expected 0", PWRITE); end
    if (PADDR !== '0)           begin n_fails++; $display("FAIL rst_paddr: got %h expected 0", PADDR); end
    if (PWDATA !== '0)          begin n_fails++; $display("FAIL rst_pwdata: got %h expected 0", PWDATA); end
    if (rsp_valid_o !== 1'b0)   begin n_fails++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid_o); end
    if (rsp_rdata_o !== '0)     begin n_fails++; $display("FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata_o); end
    if (rsp_err_o !== 1'b0)     begin n_fails++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err_o); end
    if (rsp_timeout_o !== 1'b0) begin n_fails++; $display("FAIL rst_rsp_timeout: got %b expected 0", rsp_timeout_o); end
    if (req_ready_o !== 1'b1)   begin n_fails++; $display("FAIL rst_req_ready: got %b expected 1", req_ready_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_zero_wait_write();
    int lat; int n_acc; bit bus_ok; bit hold_ok;
    run_xfer(12'h004, 1'b1, 32'hFFFF_0000, 32'hDEAD_BEEF, 1'b0, 0, lat, n_acc, bus_ok);
    n_checks += 3;
    if (lat !== 3)      begin n_fails++; $display("FAIL zw_latency: got %0d expected 3", lat); end
    if (n_acc !== 1)    begin n_fails++; $display("FAIL zw_access_cycles: got %0d expected 1", n_acc); end
    if (bus_ok !== 1'b1) begin n_fails++; $display("FAIL zw_bus_phases: got %b expected 1", bus_ok); end
    finish_rsp(0, hold_ok);
  endtask

  task automatic test_wait_read();
    int lat; int n_acc; bit bus_ok; bit hold_ok;
    run_xfer(12'h008, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 3, lat, n_acc, bus_ok);
    n_checks += 3;
    if (lat !== 6)      begin n_fails++; $display("FAIL wait_latency: got %0d expected 6", lat); end
    if (n_acc !== 4)    begin n_fails++; $display("FAIL wait_access_cycles: got %0d expected 4", n_acc); end
    if (bus_ok !== 1'b1) begin n_fails++; $display("FAIL wait_bus_stable: got %b expected 1", bus_ok); end
    finish_rsp(0, hold_ok);
  endtask

  task automatic test_slverr();
    int lat; int n_acc; bit bus_ok; bit hold_ok;
    run_xfer(12'h010, 1'b1, 32'hA5A5_0F0F, 32'h7777_7777, 1'b1, 1, lat, n_acc, bus_ok);
    n_checks += 1;
    if (lat !== 4) begin n_fails++; $display("FAIL slverr_latency: got %0d expected 4", lat); end
    finish_rsp(0, hold_ok);
    @(negedge clk);
    n_checks += 1;
    if (req_ready_o !== 1'b1) begin n_fails++; $display("FAIL slverr_ready_after: got %b expected 1", req_ready_o); end
    run_xfer(12'h014, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 0, lat, n_acc, bus_ok);
    n_checks += 1;
    if (lat !== 3) begin n_fails++; $display("FAIL slverr_next_latency: got %0d expected 3", lat); end
    finish_rsp(0, hold_ok);
  endtask

  task automatic test_timeout();
    int lat; int n_acc; bit bus_ok; bit hold_ok;
    run_xfer(12'h020, 1'b0, 32'h0, 32'hCAFE_CAFE, 1'b0, -1, lat, n_acc, bus_ok);
    n_checks += 2;
    if (lat !== 2 + int'(TO)) begin n_fails++; $display("FAIL to_latency: got %0d expected %0d", lat, 2 + TO); end
    if (n_acc !== int'(TO))   begin n_fails++; $display("FAIL to_access_cycles: got %0d expected %0d", n_acc, TO); end
    finish_rsp(0, hold_ok);
    run_xfer(12'h024, 1'b0, 32'h0, 32'h5555_AAAA, 1'b0, int'(TO) - 1, lat, n_acc, bus_ok);
    n_checks += 2;
    if (lat !== 2 + int'(TO)) begin n_fails++; $display("FAIL to_edge_latency: got %0d expected %0d", lat, 2 + TO); end
    if (bus_ok !== 1'b1)      begin n_fails++; $display("FAIL to_edge_bus: got %b expected 1", bus_ok); end
    finish_rsp(0, hold_ok);
  endtask

  task automatic test_back_pressure();
    int lat; int n_acc; bit bus_ok; bit hold_ok;
    run_xfer(12'h030, 1'b0, 32'h0, 32'h1357_9BDF, 1'b1, 2, lat, n_acc, bus_ok);
    finish_rsp(5, hold_ok);
    n_checks += 1;
    if (hold_ok !== 1'b1) begin n_fails++; $display("FAIL bp_resp_hold: got %b expected 1", hold_ok); end
  endtask

  task automatic test_reset_mid_access();
    int lat; int n_acc; bit bus_ok; bit hold_ok;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_addr_i  = 12'h0FC;
    req_write_i = 1'b1;
    req_wdata_i = 32'h1111_2222;
    @(negedge clk);
    req_valid_i = 1'b0;
    PREADY      = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 1;
    if (!(PSEL && PENABLE)) begin n_fails++; $display("FAIL rma_in_access: got psel=%b pen=%b expected 1 1", PSEL, PENABLE); end
    #2 rst_i = 1'b1;
    #1;
    n_checks += 4;
    if (PSEL !== 1'b0)        begin n_fails++; $display("FAIL rma_psel: got %b expected 0", PSEL); end
    if (PENABLE !== 1'b0)     begin n_fails++; $display("FAIL rma_penable: got %b expected 0", PENABLE); end
    if (rsp_valid_o !== 1'b0) begin n_fails++; $display("FAIL rma_rsp_valid: got %b expected 0", rsp_valid_o); end
    if (PADDR !== '0)         begin n_fails++; $display("FAIL rma_paddr: got %h expected 0", PADDR); end
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    n_checks += 1;
    if (req_ready_o !== 1'b1) begin n_fails++; $display("FAIL rma_ready_after: got %b expected 1", req_ready_o); end
    run_xfer(12'h040, 1'b0, 32'h0, 32'h89AB_CDEF, 1'b0, 1, lat, n_acc, bus_ok);
    n_checks += 2;
    if (lat !== 4)       begin n_fails++; $display("FAIL rma_fresh_latency: got %0d expected 4", lat); end
    if (bus_ok !== 1'b1) begin n_fails++; $display("FAIL rma_fresh_bus: got %b expected 1", bus_ok); end
    finish_rsp(1, hold_ok);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    PRDATA      = '0;
    PREADY      = 1'b0;
    PSLVERR     = 1'b0;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_back_pressure();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    n_checks += 1;
    if (sb_q.size() !== 0) begin n_fails++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/apb_req_master.md
Name: apb_req_master

Overview:
- APB3 initiator (master). Converts a simple valid/ready request/response port into single APB3 transfers.
- Drives the SoC peripheral APB slaves (watchdog, timers, etc.) from an internal requester such as a debug/boot sequencer.
- Supports slave wait states (PREADY), error response (PSLVERR) and a bounded access timeout so a hung slave cannot stall the requester.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR and req_addr_i.
- TIMEOUT_CYCLES, 256, max ACCESS-phase cycles before abort; 0 disables timeout.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- req_addr_i  in  APB_ADDR_WIDTH  target address.
- req_write_i  in  1  1 = write, 0 = read.
- req_wdata_i  in  32  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester accepts response.
- rsp_rdata_o  out  32  read data (0 for writes and timeouts).
- rsp_err_o  out  1  PSLVERR seen or timeout.
- rsp_timeout_o  out  1  transfer aborted by timeout.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM = IDLE.
  - PSEL = PENABLE = PWRITE = 0; PADDR = 0; PWDATA = 0.
  - rsp_valid_o = 0; rsp_rdata_o = 0; rsp_err_o = 0; rsp_timeout_o = 0.
  - Timeout counter = 0.
  - Reset during SETUP/ACCESS/RESP drops PSEL/PENABLE in the same instant; the in-flight transfer and its response are discarded.
- FSM states IDLE, SETUP, ACCESS, RESP:
  - IDLE: req_ready_o = 1 (only state where it is 1). If req_valid_i, latch addr/write/wdata into PADDR/PWRITE/PWDATA and go to SETUP.
  - SETUP: PSEL = 1, PENABLE = 0, exactly one cycle, then ACCESS; clear timeout counter.
  - ACCESS: PSEL = 1, PENABLE = 1. If PREADY, capture PRDATA (reads only; writes give 0) and PSLVERR into the rsp regs, then go to RESP. Else increment counter. If TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 with PREADY = 0: abort, rsp_err = 1, rsp_timeout = 1, rdata = 0, go to RESP.
  - RESP: PSEL = PENABLE = 0; rsp_valid_o = 1. Hold rsp_* stable until rsp_ready_i, then go to IDLE (no back-to-back acceptance in that same cycle).
- PADDR/PWRITE/PWDATA stay stable from SETUP through the end of ACCESS; the last value is held in IDLE/RESP.
- PREADY and the timeout limit in the same cycle: PREADY wins, normal completion, rsp_timeout = 0.
- PSLVERR is sampled only when PSEL & PENABLE & PREADY; ignored otherwise.
- Latency with a zero-wait slave:
  - Accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid_o at N+3.
  - Each wait state adds 1 cycle.
  - Timeout: rsp_valid_o at N+2+TIMEOUT_CYCLES.
- Throughput: at most one transfer per 4 cycles; no pipelining.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1; saturates, never wraps.

Decomposition:
- Package apb_master_pkg:
  - apb_state_e enum (IDLE, SETUP, ACCESS, RESP).
  - Response struct {rdata, err, timeout}.
  - Localparam for the default timeout.
- Sub-module apb_timeout_cnt (clear, enable, limit-reached output; parameter TIMEOUT_CYCLES) used by the FSM in ACCESS.

Test Plan:
- Zero-wait write, addr 0x004, wdata 0xFFFF_0000, slave PREADY = 1 -> PSEL at N+1, PENABLE at N+2, PWDATA = 0xFFFF_0000; rsp_valid at N+3 with err = 0, timeout = 0, rdata = 0.
- Read of addr 0x008, slave holds PREADY = 0 for 3 cycles then returns PRDATA = 0x1234_5678 -> PADDR/PSEL/PENABLE stable for 4 ACCESS cycles; rsp_rdata = 0x1234_5678 at N+6.
- Write with PSLVERR = 1 at PREADY -> rsp_err = 1, rsp_timeout = 0; next request still accepted after rsp_ready.
- TIMEOUT_CYCLES = 8, PREADY stuck 0 -> abort after 8 ACCESS cycles, rsp_err = 1, rsp_timeout = 1, rdata = 0. Same setup with PREADY rising on the 8th cycle -> normal completion, timeout = 0.
- rsp_ready_i held 0 for 5 cycles in RESP -> rsp_* stable, req_ready_o = 0, PSEL = 0 throughout.
- rst_i asserted mid-ACCESS -> PSEL/PENABLE/rsp_valid_o drop without a clock edge. After release, req_ready_o = 1 and a fresh read completes normally.
